// File: rtl/result_led_reader_pkg.sv
// result_led_pkg: shared widths, display FSM state type and nibble-select
// constants for the result_led_reader block and its result FIFO.
package result_led_pkg;

  localparam int unsigned RES_W = 10;
  localparam int unsigned LED_W = 4;

  // Bit offsets of the three nibbles shown on the LEDs.
  localparam int unsigned NIB0_LSB = 0;
  localparam int unsigned NIB1_LSB = 4;
  localparam int unsigned NIB2_LSB = 8;

  // GAP is only reachable when RESULT_LED_GAP_EN is defined.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    NIB0 = 3'd1,
    NIB1 = 3'd2,
    NIB2 = 3'd3,
    GAP  = 3'd4
  } led_state_t;

endpackage

// File: rtl/result_led_reader_fifo.sv
// result_fifo: synchronous FIFO buffering result words.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset (discards contents)
//   push, din        write din when push && !full
//   pop, dout        dout is the head word; pop removes it when !empty
//   full, empty      registered-occupancy flags
//   count            current occupancy (0..DEPTH)
// Parameter DEPTH must be a power of two, >= 2.
import result_led_pkg::*;

module result_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [RES_W-1:0]         din,
  input  logic                     pop,
  output logic [RES_W-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

  logic [RES_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage has no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/result_led_reader.sv
// result_led_reader: accepts 10-bit result words over valid/ready, buffers
// them in result_fifo and shows each word on 4 LEDs as low, mid, high
// nibble, each held for HOLD_CYCLES clocks.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   res_data, res_valid  incoming result word and its valid
//   res_ready            high when the FIFO has room
//   led                  displayed nibble (0 when idle or in the gap)
//   busy                 high whenever the display FSM is not idle
// Optional feature: define RESULT_LED_GAP_EN to insert a HOLD_CYCLES blank
// (led=0, busy=1) after every word's high nibble.
import result_led_pkg::*;

module result_led_reader #(
  parameter int unsigned HOLD_CYCLES = 25_000_000,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [RES_W-1:0] res_data,
  input  logic             res_valid,
  output logic             res_ready,
  output logic [LED_W-1:0] led,
  output logic             busy
);

  localparam int unsigned      CNT_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  led_state_t                   state;
  led_state_t                   next_state;
  logic [CNT_W-1:0]             cnt;
  logic [CNT_W-1:0]             next_cnt;
  logic [RES_W-1:0]             disp;
  logic                         pop;
  logic                         push;
  logic                         tc;
  logic [RES_W-1:0]             fifo_dout;
  logic                         fifo_full;
  logic                         fifo_empty;
  logic [$clog2(FIFO_DEPTH):0]  fifo_count;

  assign res_ready = !fifo_full;
  assign push      = res_valid && res_ready;
  assign tc        = (cnt == CNT_LAST);

  result_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (res_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // State register, hold counter and display register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      disp  <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
      if (pop) disp <= fifo_dout;
    end
  end

  // The FSM only pops a non-empty FIFO.
  always_ff @(posedge clk) begin
    if (rst_n && pop) assert (fifo_count != '0);
  end

  // Next state, counter and pop decision.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    next_cnt   = (state == IDLE || tc) ? '0 : cnt + 1'b1;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          next_state = NIB0;
        end
      end
      NIB0: if (tc) next_state = NIB1;
      NIB1: if (tc) next_state = NIB2;
`ifdef RESULT_LED_GAP_EN
      NIB2: if (tc) next_state = GAP;
      GAP: begin
`else
      NIB2: begin
`endif
        // End of a word: chain straight into the next one if buffered.
        if (tc) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            next_state = NIB0;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // LED mux and busy from registered state.
  always_comb begin
    led  = '0;
    busy = (state != IDLE);
    case (state)
      NIB0:    led = disp[NIB0_LSB +: LED_W];
      NIB1:    led = disp[NIB1_LSB +: LED_W];
      NIB2:    led = LED_W'(disp[RES_W-1:NIB2_LSB]);
      default: led = '0;
    endcase
  end

endmodule

// File: tb/tb_result_led_reader.sv
module tb_result_led_reader;

  localparam int H     = 4;
  localparam int DEPTH = 4;
`ifdef RESULT_LED_GAP_EN
  localparam int PERIOD = 4 * H;
  localparam bit GAP_EN = 1'b1;
`else
  localparam int PERIOD = 3 * H;
  localparam bit GAP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] res_data = '0;
  logic       res_valid = 1'b0;
  logic       res_ready;
  logic [3:0] led;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  result_led_reader #(
    .HOLD_CYCLES (H),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .res_data  (res_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .led       (led),
    .busy      (busy)
  );

  // Reference model: a queue of accepted words plus the word on display and
  // how many cycles of its display period have elapsed.
  logic [9:0] mq[$];
  logic [9:0] m_cur = '0;
  bit         m_active = 1'b0;
  int         m_elapsed = 0;

  task automatic model_edge();
    bit had, acc;
    if (!rst_n) begin
      mq.delete();
      m_active  = 1'b0;
      m_elapsed = 0;
      return;
    end
    had = (mq.size() > 0);
    acc = res_valid && (mq.size() < DEPTH);
    if (m_active) begin
      m_elapsed++;
      if (m_elapsed == PERIOD) begin
        if (had) begin
          m_cur     = mq.pop_front();
          m_elapsed = 0;
        end else begin
          m_active = 1'b0;
        end
      end
    end else if (had) begin
      m_cur     = mq.pop_front();
      m_active  = 1'b1;
      m_elapsed = 0;
    end
    if (acc) mq.push_back(res_data);
  endtask

  function automatic logic [3:0] model_led();
    int idx;
    if (!m_active) return 4'h0;
    idx = m_elapsed / H;
    case (idx)
      0:       return m_cur[3:0];
      1:       return m_cur[7:4];
      2:       return {2'b00, m_cur[9:8]};
      default: return 4'h0;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock with the currently driven inputs; DUT compared to the model.
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    chk("model_led", int'(led), int'(model_led()));
    chk("model_busy", int'(busy), int'(m_active));
    chk("model_ready", int'(res_ready), int'(mq.size() < DEPTH));
  endtask

  typedef struct {
    logic       rst_n;
    logic       valid;
    logic [9:0] data;
    logic [3:0] led;
    logic       busy;
    logic       ready;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic v, input logic [9:0] d,
                     input logic [3:0] l, input logic b, input logic rd, input int n);
    vec_t e;
    e.rst_n = r; e.valid = v; e.data = d; e.led = l; e.busy = b; e.ready = rd;
    for (int i = 0; i < n; i++) tbl.push_back(e);
  endtask

  initial begin
    int         k;
    int         cyc;
    int         acc_cyc[6];
    bit         seen_full;
    logic [9:0] words[6];

    // Reset, then idle with valid low.
    add(0, 0, 10'h000, 4'h0, 0, 1, 3);
    add(1, 0, 10'h000, 4'h0, 0, 1, 3);

    // Single word 2A5: 5, A, 2, then idle.
    add(1, 1, 10'h2A5, 4'h0, 0, 1, 1);
    add(1, 0, 10'h000, 4'h5, 1, 1, H);
    add(1, 0, 10'h000, 4'hA, 1, 1, H);
    add(1, 0, 10'h000, 4'h2, 1, 1, H);
    if (GAP_EN) add(1, 0, 10'h000, 4'h0, 1, 1, H);
    add(1, 0, 10'h000, 4'h0, 0, 1, 3);

    // Back-to-back 3FF then 001 with no idle cycle between them.
    add(1, 1, 10'h3FF, 4'h0, 0, 1, 1);
    add(1, 1, 10'h001, 4'hF, 1, 1, 1);
    add(1, 0, 10'h000, 4'hF, 1, 1, H - 1);
    add(1, 0, 10'h000, 4'hF, 1, 1, H);
    add(1, 0, 10'h000, 4'h3, 1, 1, H);
    if (GAP_EN) add(1, 0, 10'h000, 4'h0, 1, 1, H);
    add(1, 0, 10'h000, 4'h1, 1, 1, H);
    add(1, 0, 10'h000, 4'h0, 1, 1, H);
    add(1, 0, 10'h000, 4'h0, 1, 1, H);
    if (GAP_EN) add(1, 0, 10'h000, 4'h0, 1, 1, H);
    add(1, 0, 10'h000, 4'h0, 0, 1, 3);

    // Reset during NIB1 of 2C7 with two words queued; nothing stale after.
    add(1, 1, 10'h2C7, 4'h0, 0, 1, 1);
    add(1, 1, 10'h13B, 4'h7, 1, 1, 1);
    add(1, 1, 10'h0E4, 4'h7, 1, 1, 1);
    add(1, 0, 10'h000, 4'h7, 1, 1, H - 2);
    add(1, 0, 10'h000, 4'hC, 1, 1, 2);
    add(0, 0, 10'h000, 4'h0, 0, 1, 1);
    add(1, 0, 10'h000, 4'h0, 0, 1, 4 * PERIOD);

    foreach (tbl[i]) begin
      rst_n     = tbl[i].rst_n;
      res_valid = tbl[i].valid;
      res_data  = tbl[i].data;
      tick();
      chk($sformatf("vec%0d_led", i), int'(led), int'(tbl[i].led));
      chk($sformatf("vec%0d_busy", i), int'(busy), int'(tbl[i].busy));
      chk($sformatf("vec%0d_ready", i), int'(res_ready), int'(tbl[i].ready));
    end

    // Backpressure: six words offered with valid held high.
    words = '{10'h101, 10'h212, 10'h323, 10'h034, 10'h145, 10'h256};
    k = 0; cyc = 0; seen_full = 1'b0;
    res_valid = 1'b1;
    while (k < 6 && cyc < 200) begin
      bit acc;
      res_data = words[k];
      acc = res_ready;
      tick();
      cyc++;
      if (acc) begin
        acc_cyc[k] = cyc;
        k++;
        if (k == 5) begin
          chk("bp_ready_low_when_full", int'(res_ready), 0);
          seen_full = 1'b1;
        end
      end
    end
    res_valid = 1'b0;
    chk("bp_all_accepted", k, 6);
    chk("bp_full_seen", int'(seen_full), 1);
    if (k == 6) begin
      chk("bp_w2_after_w1", acc_cyc[1] - acc_cyc[0], 1);
      chk("bp_w5_after_w1", acc_cyc[4] - acc_cyc[0], 4);
      chk("bp_w6_after_w1", acc_cyc[5] - acc_cyc[0], PERIOD + 2);
    end
    for (int i = 0; i < 6 * PERIOD + 4; i++) tick();
    chk("bp_drained_busy", int'(busy), 0);

    // Randomized traffic with occasional resets, checked against the model.
    for (int i = 0; i < 4000; i++) begin
      rst_n     = ($urandom_range(0, 599) != 0);
      res_valid = ($urandom_range(0, 3) == 0);
      res_data  = 10'($urandom);
      tick();
    end
    rst_n = 1'b1;
    res_valid = 1'b0;
    for (int i = 0; i < 5 * PERIOD + 4; i++) tick();
    chk("final_idle", int'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
